// File: rtl/lzw_channel_scheduler.sv
// lzw_channel_scheduler: runs one shared lzw_compress core over R, G, B and packs the code streams into one memory
module lzw_channel_scheduler #(
  parameter int TOTAL_PIXELS = 256,
  parameter int OUT_DEPTH    = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  ch_sel,
  output logic        core_ap_start,
  input  logic        core_ap_done,
  input  logic        core_in_ce0,
  output logic [9:0]  in_rd_addr,
  input  logic        core_out_ce0,
  input  logic        core_out_we0,
  input  logic [15:0] core_out_d0,
  input  logic [15:0] core_out_size,
  input  logic        core_out_size_vld,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] size_r,
  output logic [15:0] size_g,
  output logic [15:0] size_b,
  output logic [11:0] base_g,
  output logic [11:0] base_b,
  output logic        overflow
);
  localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, RUN = 3'd2, GAP = 3'd3, FIN = 3'd4;
  logic [2:0]  state;
  logic [11:0] wr_ptr;
  logic [15:0] run_cnt;
  logic        seen;
  logic        wr, full, size_ld;
  logic [15:0] size_val;
  // Core write strobe, memory-full test and the per-channel size value to capture
  always_comb begin
    wr       = state == RUN && core_out_ce0 && core_out_we0;
    full     = wr_ptr == 12'(OUT_DEPTH);
    size_ld  = state == RUN && (core_out_size_vld || (core_ap_done && !seen));
    size_val = core_out_size_vld ? core_out_size : run_cnt + 16'(wr);
  end
  assign busy          = state != IDLE;
  assign done          = state == FIN;
  assign core_ap_start = state == LAUNCH || state == RUN;
  // Channel sequencing, input address generation, output packing and size/base capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch_sel     <= '0;
      in_rd_addr <= '0;
      wr_ptr     <= '0;
      run_cnt    <= '0;
      seen       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      size_r     <= '0;
      size_g     <= '0;
      size_b     <= '0;
      base_g     <= '0;
      base_b     <= '0;
      overflow   <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      mem_we <= 1'b0;
    end else begin
      mem_we <= wr && !full;
      if (wr && !full) begin
        mem_addr  <= wr_ptr;
        mem_wdata <= core_out_d0;
        wr_ptr    <= wr_ptr + 12'd1;
      end
      if (wr && full) overflow <= 1'b1;
      if (wr) run_cnt <= run_cnt + 16'd1;
      if (core_ap_start && core_in_ce0 && in_rd_addr != 10'(TOTAL_PIXELS - 1)) in_rd_addr <= in_rd_addr + 10'd1;
      if (size_ld && ch_sel == 2'd0) size_r <= size_val;
      if (size_ld && ch_sel == 2'd1) size_g <= size_val;
      if (size_ld && ch_sel == 2'd2) size_b <= size_val;
      if (state == RUN && core_out_size_vld) seen <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state      <= LAUNCH;
          ch_sel     <= '0;
          in_rd_addr <= '0;
          wr_ptr     <= '0;
          run_cnt    <= '0;
          seen       <= 1'b0;
          size_r     <= '0;
          size_g     <= '0;
          size_b     <= '0;
          base_g     <= '0;
          base_b     <= '0;
          overflow   <= 1'b0;
        end
        LAUNCH: state <= RUN;
        RUN: if (core_ap_done) state <= GAP;
        GAP: if (ch_sel == 2'd2) state <= FIN;
        else begin
          state      <= LAUNCH;
          ch_sel     <= ch_sel + 2'd1;
          in_rd_addr <= '0;
          run_cnt    <= '0;
          seen       <= 1'b0;
          if (ch_sel == 2'd0) base_g <= wr_ptr;
          else base_b <= wr_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lzw_channel_scheduler.sv
// tb_lzw_channel_scheduler: randomized core model against a stream-level reference of the packed output
module tb_lzw_channel_scheduler;
  localparam int TP = 256, D = 768;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic busy, done, core_ap_start, mem_we, overflow;
  logic [1:0] ch_sel;
  logic [9:0] in_rd_addr;
  logic core_ap_done = 0, core_in_ce0 = 0, core_out_ce0 = 0, core_out_we0 = 0, core_out_size_vld = 0;
  logic [15:0] core_out_d0 = 0, core_out_size = 0, mem_wdata, size_r, size_g, size_b;
  logic [11:0] mem_addr, base_g, base_b;
  int checks = 0, failures = 0, done_cnt = 0;
  int pre[3], exp_sz[3];
  logic [15:0] words[$], log_d[$];
  logic [11:0] log_a[$];

  lzw_channel_scheduler #(.TOTAL_PIXELS(TP), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .ch_sel(ch_sel), .core_ap_start(core_ap_start), .core_ap_done(core_ap_done),
    .core_in_ce0(core_in_ce0), .in_rd_addr(in_rd_addr), .core_out_ce0(core_out_ce0),
    .core_out_we0(core_out_we0), .core_out_d0(core_out_d0), .core_out_size(core_out_size),
    .core_out_size_vld(core_out_size_vld), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .size_r(size_r), .size_g(size_g), .size_b(size_b),
    .base_g(base_g), .base_b(base_b), .overflow(overflow));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return a < b ? a : b;
  endfunction

  function automatic logic [15:0] size_of(input int c);
    return c == 0 ? size_r : c == 1 ? size_g : size_b;
  endfunction

  task automatic check_stream(input int exp_done);
    int exp_cnt = min_i(words.size(), D);
    int bad = 0;
    chk("wr_count", log_a.size(), exp_cnt);
    for (int i = 0; i < exp_cnt && i < log_a.size(); i++)
      if (log_a[i] !== 12'(i) || log_d[i] !== words[i]) bad++;
    chk("wr_addr_data", bad, 0);
    if (exp_cnt > 0 && log_a.size() > 0) chk("last_addr", log_a[log_a.size() - 1], exp_cnt - 1);
    chk("overflow", overflow, words.size() > D);
    chk("done_pulses", done_cnt, exp_done);
  endtask

  task automatic run_chan(input int c, input int n, input int vm, input int ab, input bit rs, output bit stop);
    int pulses = 0, w = 0, cyc = 0;
    bit wr;
    stop = 0;
    chk("ch_sel", ch_sel, c);
    chk("ap_start_launch", core_ap_start, 1);
    chk("rd_addr_zero", in_rd_addr, 0);
    core_in_ce0 = 1'($urandom_range(0, 1));
    pulses += core_in_ce0;
    step();
    while (w < n) begin
      if (ab >= 0 && cyc == ab) begin
        {core_out_ce0, core_out_we0, core_in_ce0, core_out_size_vld, start} = '0;
        stop = 1;
        if (rs) begin
          #2 rst_n = 0;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_ap_start", core_ap_start, 0);
          chk("rst_mem_we", mem_we, 0);
          chk("rst_regs", {ch_sel, in_rd_addr, mem_addr, size_r, base_g, overflow, done}, 0);
          step();
          rst_n = 1;
          step();
        end else begin
          abort = 1;
          step();
          abort = 0;
          chk("abort_ap_start", core_ap_start, 0);
          chk("abort_busy", busy, 0);
          chk("abort_mem_we", mem_we, 0);
          chk("abort_size_r", size_r, exp_sz[0]);
          repeat (2) step();
        end
        return;
      end
      core_out_ce0 = $urandom_range(0, 3) != 0;
      core_out_we0 = $urandom_range(0, 3) != 0;
      wr = core_out_ce0 && core_out_we0;
      core_out_d0 = 16'($urandom);
      if (wr) begin
        words.push_back(core_out_d0);
        w++;
      end
      core_in_ce0 = $urandom_range(0, 3) != 0;
      pulses += core_in_ce0;
      start = 1'($urandom_range(0, 1));
      core_out_size_vld = vm == 1 && cyc == 0;
      core_out_size = 16'(n);
      cyc++;
      step();
    end
    {core_out_ce0, core_out_we0, core_in_ce0, start} = '0;
    core_ap_done = 1;
    core_out_size_vld = vm >= 2;
    core_out_size = 16'(vm == 3 ? n + 7 : n);
    exp_sz[c] = vm == 3 ? n + 7 : n;
    step();
    core_ap_done = 0;
    core_out_size_vld = 0;
    chk("gap_ap_start", core_ap_start, 0);
    chk("gap_busy", busy, 1);
    chk("rd_addr_end", in_rd_addr, min_i(pulses, TP - 1));
    chk("size_capture", size_of(c), exp_sz[c]);
    step();
  endtask

  task automatic run_job(input int n0, v0, n1, v1, n2, v2, input int ab_ch, ab_cyc, input bit rs);
    int n[3] = '{n0, n1, n2};
    int v[3] = '{v0, v1, v2};
    bit stop = 0;
    words.delete();
    log_a.delete();
    log_d.delete();
    done_cnt = 0;
    exp_sz = '{0, 0, 0};
    start = 1;
    step();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_size_clear", {size_r, size_g, size_b, overflow}, 0);
    for (int c = 0; c < 3 && !stop; c++) begin
      if (c == 1) chk("base_g", base_g, min_i(pre[0], D));
      if (c == 2) chk("base_b", base_b, min_i(pre[1], D));
      run_chan(c, n[c], v[c], c == ab_ch ? ab_cyc : -1, rs, stop);
      pre[c] = words.size();
    end
    if (rs) return;
    if (!stop) begin
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 1);
      step();
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      step();
    end
    check_stream(stop ? 0 : 1);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {busy, done, core_ap_start, mem_we, ch_sel, in_rd_addr, mem_addr, mem_wdata}, 0);
    chk("reset_regs", {size_r, size_g, size_b, base_g, base_b, overflow}, 0);
    step();
    start = 1;
    abort = 1;
    rst_n = 1;
    step();
    start = 0;
    abort = 0;
    chk("start_abort_idle", busy, 0);
    run_job(100, 1, 80, 2, 120, 1, -1, 0, 0);
    run_job(60, 2, 50, 0, 70, 3, -1, 0, 0);
    run_job(300, 1, 250, 2, 260, 1, -1, 0, 0);
    run_job(40, 1, 30, 2, 20, 0, 1, 5, 0);
    run_job(30, 0, 20, 1, 25, 2, -1, 0, 0);
    run_job(25, 2, 35, 1, 45, 0, 2, 10, 1);
    run_job(15, 1, 12, 3, 18, 2, -1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
